// File: rtl/conv_job_ctrl.sv
`timescale 1ns/1ps
// Job-level sequencer for one convolution pass: latches a layer config, runs the
// prepare stage, then the matrix and result phases, and reports completion status.
module conv_job_ctrl #(
    parameter int PREP_TIMEOUT = 255,
    parameter int CNT_W        = 16,
    parameter int TENSOR_W     = 8,
    parameter int KERNEL_W     = 8,
    parameter int CHANNELS_W   = 8,
    parameter int STRIDE_W     = 4,
    parameter int KNUMS_W      = 8
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  cfg_valid,
    output logic                  cfg_ready,
    input  logic [TENSOR_W-1:0]   cfg_tensor_size,
    input  logic [KERNEL_W-1:0]   cfg_kernel_size,
    input  logic [CHANNELS_W-1:0] cfg_channels,
    input  logic [STRIDE_W-1:0]   cfg_stride,
    input  logic [KNUMS_W-1:0]    cfg_kernel_nums,
    output logic [TENSOR_W-1:0]   prep_tensor_size,
    output logic [KERNEL_W-1:0]   prep_kernel_size,
    output logic [CHANNELS_W-1:0] prep_channels,
    output logic [STRIDE_W-1:0]   prep_stride,
    output logic [KNUMS_W-1:0]    prep_kernel_nums,
    output logic                  prep_rstn,
    output logic                  prep_start,
    input  logic                  prep_enable,
    output logic                  mm_start,
    input  logic                  mm_done,
    output logic                  res_start,
    input  logic                  res_done,
    input  logic                  abort,
    output logic                  busy,
    output logic                  job_done,
    output logic [1:0]            job_err,
    output logic [CNT_W-1:0]      job_count
);

    localparam int TMO_W = (PREP_TIMEOUT < 2) ? 1 : $clog2(PREP_TIMEOUT);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(PREP_TIMEOUT - 1);

    localparam logic [1:0] ERR_OK    = 2'd0;
    localparam logic [1:0] ERR_CFG   = 2'd1;
    localparam logic [1:0] ERR_TMO   = 2'd2;
    localparam logic [1:0] ERR_ABORT = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREP,
        S_MM,
        S_RES,
        S_DONE
    } state_t;

    state_t                state_q, state_d;
    logic [TMO_W-1:0]      tmo_q, tmo_d;
    logic                  first_q, first_d;
    logic [1:0]            err_q, err_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [TENSOR_W-1:0]   tsize_q, tsize_d;
    logic [KERNEL_W-1:0]   ksize_q, ksize_d;
    logic [CHANNELS_W-1:0] chan_q, chan_d;
    logic [STRIDE_W-1:0]   stride_q, stride_d;
    logic [KNUMS_W-1:0]    knums_q, knums_d;
    logic                  cfg_bad;

    assign cfg_bad = (cfg_kernel_size == '0) || (cfg_stride == '0) ||
                     (cfg_channels == '0) || (cfg_kernel_nums == '0) ||
                     (32'(cfg_kernel_size) > 32'(cfg_tensor_size));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= S_IDLE;
            tmo_q    <= '0;
            first_q  <= 1'b0;
            err_q    <= ERR_OK;
            cnt_q    <= '0;
            tsize_q  <= '0;
            ksize_q  <= '0;
            chan_q   <= '0;
            stride_q <= '0;
            knums_q  <= '0;
        end else begin
            state_q  <= state_d;
            tmo_q    <= tmo_d;
            first_q  <= first_d;
            err_q    <= err_d;
            cnt_q    <= cnt_d;
            tsize_q  <= tsize_d;
            ksize_q  <= ksize_d;
            chan_q   <= chan_d;
            stride_q <= stride_d;
            knums_q  <= knums_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        tmo_d    = tmo_q;
        first_d  = 1'b0;
        err_d    = err_q;
        cnt_d    = cnt_q;
        tsize_d  = tsize_q;
        ksize_d  = ksize_q;
        chan_d   = chan_q;
        stride_d = stride_q;
        knums_d  = knums_q;

        unique case (state_q)
            S_IDLE: begin
                if (cfg_valid) begin
                    tsize_d  = cfg_tensor_size;
                    ksize_d  = cfg_kernel_size;
                    chan_d   = cfg_channels;
                    stride_d = cfg_stride;
                    knums_d  = cfg_kernel_nums;
                    tmo_d    = '0;
                    if (cfg_bad) begin
                        state_d = S_DONE;
                        err_d   = ERR_CFG;
                    end else begin
                        state_d = S_PREP;
                        err_d   = ERR_OK;
                    end
                end
            end
            S_PREP: begin
                if (abort) begin
                    state_d = S_DONE;
                    err_d   = ERR_ABORT;
                end else if (prep_enable) begin
                    state_d = S_MM;
                    first_d = 1'b1;
                end else if (tmo_q == TMO_LAST) begin
                    state_d = S_DONE;
                    err_d   = ERR_TMO;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            // Completion inputs are ignored during the start-pulse cycle of each phase.
            S_MM: begin
                if (abort) begin
                    state_d = S_DONE;
                    err_d   = ERR_ABORT;
                end else if (!first_q && mm_done) begin
                    state_d = S_RES;
                    first_d = 1'b1;
                end
            end
            S_RES: begin
                if (abort) begin
                    state_d = S_DONE;
                    err_d   = ERR_ABORT;
                end else if (!first_q && res_done) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                if (err_q == ERR_OK) cnt_d = cnt_q + CNT_W'(1);
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign cfg_ready        = (state_q == S_IDLE);
    assign busy             = (state_q != S_IDLE);
    assign prep_rstn        = (state_q != S_IDLE);
    assign prep_start       = (state_q == S_PREP);
    assign mm_start         = (state_q == S_MM) && first_q;
    assign res_start        = (state_q == S_RES) && first_q;
    assign job_done         = (state_q == S_DONE);
    assign job_err          = err_q;
    assign job_count        = cnt_q;
    assign prep_tensor_size = tsize_q;
    assign prep_kernel_size = ksize_q;
    assign prep_channels    = chan_q;
    assign prep_stride      = stride_q;
    assign prep_kernel_nums = knums_q;

endmodule

// File: tb/tb_conv_job_ctrl.sv
`timescale 1ns/1ps
// Randomized bench for conv_job_ctrl: a reactive stub plays the prepare/matrix/result
// stages and a job-level timing model predicts each job's outcome.
module tb_conv_job_ctrl;

    localparam int T     = 16;
    localparam int CNT_W = 16;
    localparam int TW = 8, KW = 8, CW = 8, SW = 4, NW = 8;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          cfg_valid = 1'b0;
    logic          cfg_ready;
    logic [TW-1:0] cfg_tensor_size = '0;
    logic [KW-1:0] cfg_kernel_size = '0;
    logic [CW-1:0] cfg_channels = '0;
    logic [SW-1:0] cfg_stride = '0;
    logic [NW-1:0] cfg_kernel_nums = '0;
    logic [TW-1:0] prep_tensor_size;
    logic [KW-1:0] prep_kernel_size;
    logic [CW-1:0] prep_channels;
    logic [SW-1:0] prep_stride;
    logic [NW-1:0] prep_kernel_nums;
    logic          prep_rstn, prep_start, mm_start, res_start;
    logic          prep_enable = 1'b0, mm_done = 1'b0, res_done = 1'b0, abort = 1'b0;
    logic          busy, job_done;
    logic [1:0]    job_err;
    logic [CNT_W-1:0] job_count;

    conv_job_ctrl #(
        .PREP_TIMEOUT(T), .CNT_W(CNT_W), .TENSOR_W(TW), .KERNEL_W(KW),
        .CHANNELS_W(CW), .STRIDE_W(SW), .KNUMS_W(NW)
    ) dut (
        .clk(clk), .rstn(rstn), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_tensor_size(cfg_tensor_size), .cfg_kernel_size(cfg_kernel_size),
        .cfg_channels(cfg_channels), .cfg_stride(cfg_stride),
        .cfg_kernel_nums(cfg_kernel_nums),
        .prep_tensor_size(prep_tensor_size), .prep_kernel_size(prep_kernel_size),
        .prep_channels(prep_channels), .prep_stride(prep_stride),
        .prep_kernel_nums(prep_kernel_nums),
        .prep_rstn(prep_rstn), .prep_start(prep_start), .prep_enable(prep_enable),
        .mm_start(mm_start), .mm_done(mm_done), .res_start(res_start),
        .res_done(res_done), .abort(abort), .busy(busy), .job_done(job_done),
        .job_err(job_err), .job_count(job_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int ts, ks, ch, st, kn;
        int dp, dm, dr, ab;
    } job_t;

    int n_chk = 0;
    int n_err = 0;
    int exp_count = 0;
    int last_err = 0;
    bit mm_hold = 1'b0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic bit is_bad(input job_t j);
        return (j.ks == 0) || (j.st == 0) || (j.ch == 0) || (j.kn == 0) || (j.ks > j.ts);
    endfunction

    task automatic drive_cfg(input job_t j);
        cfg_tensor_size = TW'(j.ts);
        cfg_kernel_size = KW'(j.ks);
        cfg_channels    = CW'(j.ch);
        cfg_stride      = SW'(j.st);
        cfg_kernel_nums = NW'(j.kn);
        cfg_valid       = 1'b1;
    endtask

    // Runs one job from offer to the job_done cycle; returns positioned in that cycle.
    task automatic run_job(input job_t j);
        bit bad, reach_mm, acc, got, rdy;
        int p, m, r, e, done_exp, err_exp, pexp, mexp, rexp;
        int w, k, pc, mc, rc, ms, rs, ctl_bad, done_k, err_got;
        bit pe;
        logic [63:0] cfg_cat;

        bad = is_bad(j);
        p = 0; m = 0; r = 0; reach_mm = 0;
        if (bad) begin
            done_exp = 1; err_exp = 1;
        end else begin
            if (j.dp + 1 <= T) begin
                p = j.dp + 1;
                m = mm_hold ? 2 : ((j.dm + 1 < 2) ? 2 : j.dm + 1);
                r = (j.dr + 1 < 2) ? 2 : j.dr + 1;
                e = p + m + r; err_exp = 0; reach_mm = 1;
            end else begin
                p = T; e = T; err_exp = 2;
            end
            if (j.ab >= 1 && j.ab <= e) begin
                done_exp = j.ab + 1; err_exp = 3;
            end else begin
                done_exp = e + 1;
            end
        end
        pexp = bad ? 0 : ((p < done_exp - 1) ? p : done_exp - 1);
        mexp = (!bad && reach_mm && (done_exp - 1 > p)) ? 1 : 0;
        rexp = (!bad && reach_mm && (done_exp - 1 > p + m)) ? 1 : 0;

        drive_cfg(j);
        w = 0; acc = 0;
        while (!acc && w < 20) begin
            rdy = cfg_ready;
            @(posedge clk); #1;
            w++;
            if (rdy) acc = 1;
        end
        cfg_valid = 1'b0;
        chk("accept_wait", w, 1);
        cfg_cat = {prep_tensor_size, prep_kernel_size, prep_channels, prep_stride, prep_kernel_nums};
        chk("prep_cfg", cfg_cat, {TW'(j.ts), KW'(j.ks), CW'(j.ch), SW'(j.st), NW'(j.kn)});

        pc = 0; mc = 0; rc = 0; ms = -1; rs = -1; ctl_bad = 0; pe = 0;
        got = 0; done_k = 0; err_got = 0;
        for (k = 1; k <= 300 && !got; k++) begin
            if (!prep_rstn || cfg_ready || !busy) ctl_bad++;
            if (mm_start) begin mc++; ms = k; end
            if (res_start) begin rc++; rs = k; end
            if (job_done) begin
                got = 1; done_k = k; err_got = int'(job_err);
                chk("count_in_done", job_count, CNT_W'(exp_count));
            end else begin
                if (prep_start) begin
                    if (pc >= j.dp) pe = 1;
                    pc++;
                end
                prep_enable = pe;
                mm_done  = mm_hold || (ms >= 0 && k - ms >= j.dm);
                res_done = (rs >= 0 && k - rs >= j.dr);
                abort    = (k == j.ab);
                @(posedge clk); #1;
            end
        end
        prep_enable = 1'b0; mm_done = mm_hold; res_done = 1'b0; abort = 1'b0;

        chk("done_cycle", done_k, done_exp);
        chk("err_code", err_got, err_exp);
        chk("prep_start_cycles", pc, pexp);
        chk("mm_start_cycles", mc, mexp);
        chk("res_start_cycles", rc, rexp);
        chk("ctl_during_job", ctl_bad, 0);
        if (err_exp == 0) exp_count = (exp_count + 1) % (1 << CNT_W);
        last_err = err_exp;
    endtask

    // Steps into the IDLE cycle following DONE and checks its outputs.
    task automatic after_job();
        @(posedge clk); #1;
        chk("idle_ctl", {cfg_ready, prep_rstn, busy, prep_start, mm_start, res_start, job_done},
            7'b1000000);
        chk("idle_count", job_count, CNT_W'(exp_count));
        chk("idle_err_held", job_err, last_err);
    endtask

    task automatic check_reset_vals(input string tag);
        logic [63:0] cfg_cat;
        cfg_cat = {prep_tensor_size, prep_kernel_size, prep_channels, prep_stride, prep_kernel_nums};
        chk({tag, "_ctl"}, {cfg_ready, prep_rstn, busy, prep_start, mm_start, res_start, job_done},
            7'b1000000);
        chk({tag, "_err"}, job_err, 0);
        chk({tag, "_count"}, job_count, 0);
        chk({tag, "_cfg"}, cfg_cat, 0);
    endtask

    function automatic job_t rand_job();
        job_t j;
        if ($urandom_range(0, 4) == 0) begin
            j.ts = $urandom_range(0, 15); j.ks = $urandom_range(0, 15);
            j.ch = $urandom_range(0, 3);  j.st = $urandom_range(0, 3);
            j.kn = $urandom_range(0, 3);
        end else begin
            j.ts = $urandom_range(1, 255); j.ks = $urandom_range(1, j.ts);
            j.ch = $urandom_range(1, 255); j.st = $urandom_range(1, 15);
            j.kn = $urandom_range(1, 255);
        end
        j.dp = $urandom_range(0, 20);
        j.dm = $urandom_range(0, 12);
        j.dr = $urandom_range(0, 8);
        j.ab = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 40) : 0;
        return j;
    endfunction

    initial begin
        job_t ja, jb, cur, nxt;
        int w;
        bit seen;

        repeat (3) @(posedge clk);
        #1;
        check_reset_vals("reset");
        rstn = 1'b1;
        @(posedge clk); #1;

        // Nominal job
        ja = '{ts: 8, ks: 3, ch: 4, st: 1, kn: 8, dp: 6, dm: 10, dr: 4, ab: 0};
        run_job(ja);
        after_job();

        // Bad config
        ja = '{ts: 4, ks: 5, ch: 4, st: 1, kn: 8, dp: 0, dm: 0, dr: 0, ab: 0};
        run_job(ja);
        after_job();

        // Prepare stage never ready
        ja = '{ts: 8, ks: 3, ch: 4, st: 1, kn: 8, dp: 1000, dm: 0, dr: 0, ab: 0};
        run_job(ja);
        after_job();

        // Abort in the same cycle mm_done first rises (P=3, mm_done in MM cycle 6)
        ja = '{ts: 8, ks: 3, ch: 4, st: 1, kn: 8, dp: 2, dm: 5, dr: 3, ab: 9};
        run_job(ja);
        after_job();

        // mm_done held high before the job starts
        mm_hold = 1'b1; mm_done = 1'b1;
        @(posedge clk); #1;
        ja = '{ts: 8, ks: 3, ch: 4, st: 1, kn: 8, dp: 1, dm: 10, dr: 2, ab: 0};
        run_job(ja);
        mm_hold = 1'b0; mm_done = 1'b0;
        after_job();

        // Back-to-back: second config offered during DONE
        ja = '{ts: 8, ks: 3, ch: 4, st: 1, kn: 8, dp: 0, dm: 2, dr: 1, ab: 0};
        jb = '{ts: 16, ks: 16, ch: 2, st: 2, kn: 3, dp: 3, dm: 0, dr: 0, ab: 0};
        run_job(ja);
        drive_cfg(jb);
        after_job();
        run_job(jb);
        after_job();

        // Async reset in the middle of the matrix phase
        ja = '{ts: 8, ks: 3, ch: 4, st: 1, kn: 8, dp: 0, dm: 0, dr: 0, ab: 0};
        drive_cfg(ja);
        @(posedge clk); #1;
        cfg_valid = 1'b0;
        prep_enable = 1'b1;
        seen = 0; w = 0;
        while (!seen && w < 10) begin
            if (mm_start) seen = 1;
            @(posedge clk); #1;
            w++;
        end
        chk("midreset_mm_seen", seen, 1);
        #2 rstn = 1'b0;
        #1;
        check_reset_vals("midreset");
        prep_enable = 1'b0;
        exp_count = 0; last_err = 0;
        @(posedge clk); #1;
        rstn = 1'b1;
        @(posedge clk); #1;

        // Randomized jobs, randomly back-to-back
        cur = rand_job();
        for (int i = 0; i < 40; i++) begin
            run_job(cur);
            nxt = rand_job();
            if ($urandom_range(0, 1) == 1) drive_cfg(nxt);
            after_job();
            cur = nxt;
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
